mem_io_responder: RTL and testbench

//   Responder on the MEM-stage data bus: the target end of the en/we/addr/wdata/rdata

---
 rtl/mem_io_responder.sv | 139 +++++++++++++
 tb/tb_mem_io_responder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// MEM-stage bus responder for a 4-word I/O window: TX FIFO, RX capture register and cycle counter.
// Reads are registered (one cycle latency); rdata is 0 on any non-hit-read cycle so it can be OR-ed.
module mem_io_responder #(
    parameter int unsigned        ADDR_W     = 14,
    parameter logic [ADDR_W-1:0]  BASE       = 14'h3FFC,
    parameter int unsigned        FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              hit,
    output logic [31:0]       tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [31:0]       rx_data,
    input  logic              rx_strobe
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_RXDATA = 2'd2;
    localparam logic [1:0] OFF_CYCLE  = 2'd3;

    logic [31:0]      rdata_q, rdata_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tx_drop_q, tx_drop_d;
    logic [31:0]      rx_reg_q, rx_reg_d;
    logic             rx_full_q, rx_full_d;
    logic             rx_overrun_q, rx_overrun_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [31:0]      mem_q [FIFO_DEPTH];

    logic        rd_hit, wr_hit, push, pop, push_ok, tx_full, tx_empty;
    logic        rx_rd, status_wr;
    logic [2:0]  count_sat;
    logic [31:0] count_ext;
    logic [31:0] status_word;
    logic [1:0]  off;

    assign hit      = (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign off      = addr[1:0];
    assign rdata    = rdata_q;
    assign tx_data  = mem_q[rd_ptr_q];
    assign tx_valid = (count_q != '0);

    // Bus decode, FIFO bookkeeping, sticky flags and read mux.
    always_comb begin
        rd_hit    = en & ~we & hit;
        wr_hit    = we & hit;
        tx_full   = (count_q == CNT_W'(FIFO_DEPTH));
        tx_empty  = (count_q == '0);
        pop       = tx_valid & tx_ready;
        push      = wr_hit & (off == OFF_TXDATA);
        push_ok   = push & (~tx_full | pop);
        rx_rd     = rd_hit & (off == OFF_RXDATA);
        status_wr = wr_hit & (off == OFF_STATUS);

        count_ext = 32'(count_q);
        count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
        status_word = {24'b0, rx_overrun_q, tx_drop_q, rx_full_q, tx_empty, tx_full, count_sat};

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        // Set events win over a same-cycle W1C clear.
        tx_drop_d    = (push & tx_full & ~pop)
                     | (tx_drop_q & ~(status_wr & wdata[6]));
        rx_overrun_d = (rx_strobe & rx_full_q & ~rx_rd)
                     | (rx_overrun_q & ~(status_wr & wdata[7]));

        rx_reg_d  = rx_strobe ? rx_data : rx_reg_q;
        rx_full_d = rx_strobe ? 1'b1 : (rx_rd ? 1'b0 : rx_full_q);

        // A load lands with this edge's tick already applied, so the next read sees wdata+1.
        if (wr_hit && (off == OFF_CYCLE)) begin
            cycle_d = wdata + 32'd1;
        end else begin
            cycle_d = cycle_q + 32'd1;
        end

        rdata_d = '0;
        if (rd_hit) begin
            unique case (off)
                OFF_TXDATA: rdata_d = '0;
                OFF_STATUS: rdata_d = status_word;
                OFF_RXDATA: rdata_d = rx_reg_q;
                OFF_CYCLE:  rdata_d = cycle_q;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_drop_q    <= 1'b0;
            rx_reg_q     <= '0;
            rx_full_q    <= 1'b0;
            rx_overrun_q <= 1'b0;
            cycle_q      <= '0;
        end else begin
            rdata_q      <= rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tx_drop_q    <= tx_drop_d;
            rx_reg_q     <= rx_reg_d;
            rx_full_q    <= rx_full_d;
            rx_overrun_q <= rx_overrun_d;
            cycle_q      <= cycle_d;
        end
    end

    // FIFO storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: window decode, TX FIFO, RX capture, cycle counter, async reset.
module tb_mem_io_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_strobe;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    localparam logic [13:0] A_TX  = 14'h3FFC;
    localparam logic [13:0] A_ST  = 14'h3FFD;
    localparam logic [13:0] A_RX  = 14'h3FFE;
    localparam logic [13:0] A_CYC = 14'h3FFF;

    mem_io_responder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hit       (hit),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [31:0] d);
        we = 1'b1; en = 1'b0; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [13:0] a, input logic [31:0] exp);
        en = 1'b1; we = 1'b0; addr = a;
        tick();
        en = 1'b0;
        check(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tx_ready = 1'b0; rx_data = '0; rx_strobe = 1'b0;
        tick();
        tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        rst = 1'b0;

        // 1: status after reset
        addr = A_ST; #1;
        check("hit_status", 32'(hit), 32'h1);
        bus_rd("status_reset", A_ST, 32'h10);
        check("tx_valid_empty", 32'(tx_valid), 32'h0);

        // 2: fill, overflow, drain
        for (int i = 1; i <= 5; i++) bus_wr(A_TX, 32'(i));
        bus_rd("status_full_drop", A_ST, 32'h4C);
        bus_rd("txdata_reads_zero", A_TX, 32'h0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("pop_%0d", i), tx_data, 32'(i));
            tick();
        end
        tx_ready = 1'b0;
        check("tx_valid_drained", 32'(tx_valid), 32'h0);
        bus_rd("status_drained", A_ST, 32'h50);

        // 3: push and pop together while full, then W1C of tx_drop
        for (int i = 0; i < 4; i++) bus_wr(A_TX, 32'h10 + 32'(i));
        tx_ready = 1'b1;
        bus_wr(A_TX, 32'h20);
        tx_ready = 1'b0;
        bus_rd("status_pushpop_full", A_ST, 32'h4C);
        bus_wr(A_ST, 32'h40);
        bus_rd("status_drop_clr", A_ST, 32'h0C);
        tx_ready = 1'b1;
        check("head_11", tx_data, 32'h11); tick();
        check("head_12", tx_data, 32'h12); tick();
        check("head_13", tx_data, 32'h13); tick();
        check("head_20", tx_data, 32'h20); tick();
        tx_ready = 1'b0;
        check("tx_valid_after3", 32'(tx_valid), 32'h0);

        // 4: RX overrun and coincident strobe with read
        rx_strobe = 1'b1; rx_data = 32'hAAAA_0001; tick();
        rx_data = 32'hBBBB_0002; tick();
        rx_strobe = 1'b0;
        bus_rd("status_overrun", A_ST, 32'hB0);
        bus_rd("rx_latest", A_RX, 32'hBBBB_0002);
        bus_rd("status_rx_read", A_ST, 32'h90);
        bus_wr(A_ST, 32'h80);
        bus_rd("status_ovr_clr", A_ST, 32'h10);
        rx_strobe = 1'b1; rx_data = 32'hCCCC_0003; tick();
        rx_data = 32'hDDDD_0004;
        bus_rd("rx_coincident_old", A_RX, 32'hCCCC_0003);
        rx_strobe = 1'b0;
        bus_rd("status_coincident", A_ST, 32'h30);
        bus_rd("rx_new_word", A_RX, 32'hDDDD_0004);
        bus_rd("status_rx_empty", A_ST, 32'h10);

        // 5: cycle counter wrap
        bus_wr(A_CYC, 32'hFFFF_FFFE);
        bus_rd("cycle_ff", A_CYC, 32'hFFFF_FFFF);
        bus_rd("cycle_wrap", A_CYC, 32'h0);

        // 6: miss, then async reset with data in the FIFO
        addr = 14'h0100; #1;
        check("hit_miss", 32'(hit), 32'h0);
        bus_rd("rdata_miss", 14'h0100, 32'h0);
        bus_wr(A_TX, 32'h55);
        bus_wr(A_TX, 32'h66);
        bus_rd("status_two", A_ST, 32'h02);
        check("tx_valid_two", 32'(tx_valid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'h0);
        check("async_rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;
        bus_rd("cycle_after_rst", A_CYC, 32'h0);
        bus_rd("status_after_rst", A_ST, 32'h10);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
